// File: rtl/multiplier_top.sv
// Sequential unsigned shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Uses the same start/done handshake as the divider, so it can rebuild a dividend from a quotient.
module multiplier_top #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               multiplier_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state;
    logic [WIDTH:0] acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]  count;
    logic [WIDTH:0] sum;

    // One extra bit on the accumulator absorbs the carry of A + M.
    always_comb begin
        sum = acc + (q_reg[0] ? {1'b0, m_reg} : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            acc             <= '0;
            q_reg           <= '0;
            m_reg           <= '0;
            count           <= '0;
            product         <= '0;
            busy            <= 1'b0;
            multiplier_done <= 1'b0;
        end else begin
            multiplier_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        acc   <= {1'b0, addend};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    {acc, q_reg} <= {sum, q_reg} >> 1;
                    count        <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                DONE: begin
                    product         <= {acc[WIDTH-1:0], q_reg};
                    multiplier_done <= 1'b1;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
